serial_tx: RTL
==============

# serial_tx

Parallel-in, serial-out frame transmitter: the sending end of the single-bit serial link our D flip-flop capture stages sample on the receive side. It accepts a parallel word on a one-cycle `Start` request and shifts it out LSB-first, framed by one start bit (0) and one stop bit (1). Each bit is held for a programmable number of clock cycles. It sits between a parallel data source and the serial line, reporting `Busy` while a frame is in flight and pulsing `Done` when the frame completes.

## Interface
- `DATA_W`, default 8: payload width in bits; must be ≥1.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held on `Q`; must be ≥1.
- `En`  input  1: clock; all state updates on the posedge of `En`.
- `reset`  input  1: synchronous, active-high reset; sampled on posedge `En`.
- `Start`  input  1: transmit request; honoured only while idle.
- `Din`  input  DATA_W: payload; captured on the edge that accepts `Start`.
- `Q`  output  1: serial line; idles high; registered.
- `Busy`  output  1: high from frame acceptance until frame end; registered.
- `Done`  output  1: one-cycle pulse marking frame completion; registered.

## Operation
- The state machine has four states (five with parity): IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE**: `Q=1`, `Busy=0`. A posedge with `Start=1` does the following:
  - latches `Din` into an internal shift register;
  - sets `Busy=1`;
  - clears the bit-tick counter and the bit index;
  - enters START.
- **START**: `Q=0` for CLKS_PER_BIT cycles, then moves to DATA.
- **DATA**: `Q` equals shift-register bit 0. Every CLKS_PER_BIT cycles the register shifts right and the bit index increments. After DATA_W bits, the machine moves to PARITY if compiled in, otherwise to STOP.
- **PARITY**: `Q` is the even-parity bit, i.e. the XOR of the latched payload. It is held for CLKS_PER_BIT cycles, then the machine moves to STOP.
- **STOP**: `Q=1` for CLKS_PER_BIT cycles. The edge that ends STOP enters IDLE, clears `Busy`, and sets `Done=1` for exactly one cycle.
- `Start` asserted while `Busy=1` is ignored; it is not queued. `Din` changes while busy have no effect.
- Counter sizing:
  - The bit-tick counter is wide enough for CLKS_PER_BIT−1 and wraps to 0 at each bit boundary.
  - The bit index is wide enough for DATA_W−1.
  - No counter may overflow for any legal parameter value.
- When CLKS_PER_BIT=1, each bit lasts exactly one cycle and the same state sequence applies.
- **Reset** (any cycle, including mid-frame): next state IDLE, `Q=1`, `Busy=0`, `Done=0`, counters cleared. A partial frame is abandoned with no `Done`. `reset` has priority over `Start` on the same edge.

## Timing
- Let P = 1 with parity, 0 without. Frame length F = (DATA_W + 2 + P) × CLKS_PER_BIT cycles.
- If `Start` is accepted at edge k:
  - `Busy=1` and `Q=0` are visible immediately after edge k;
  - the first data bit appears after edge k + CLKS_PER_BIT;
  - after edge k + F, the block is back in IDLE with `Q=1`, `Busy=0`, `Done=1`.
- `Done` is deasserted after edge k + F + 1.
- A `Start` held high during the `Done` cycle is accepted at edge k + F + 1. The start bit appears on `Q` immediately after that edge, so back-to-back frames are separated by exactly one idle-high cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in and one even-parity bit is inserted between the last data bit and the stop bit (P = 1).
- Undefined: there is no PARITY state, DATA goes directly to STOP, and no parity logic is synthesised (P = 0).

## Test plan
- **Reset values.** `reset=1` for 2 cycles with `Start=1` → `Q=1`, `Busy=0`, `Done=0` throughout, and no frame starts.
- **Basic frame, no parity.** DATA_W=8, CLKS_PER_BIT=4, `Din=8'hA5`, 1-cycle `Start`:
  - `Q` carries the bit sequence 0,1,0,1,0,0,1,0,1,1, with each bit held 4 cycles;
  - `Done` pulses 40 cycles after acceptance;
  - `Busy` is high for exactly those 40 cycles.
- **Parity frame.** `SERIAL_TX_PARITY_EN` defined:
  - `Din=8'hA5` → parity bit 0 and a 44-cycle frame;
  - `Din=8'h07` → parity bit 1.
- **Busy and back-to-back.** `Start` pulsed again mid-frame with `Din=8'hFF` → ignored, and the first frame completes unchanged. `Start` held through the `Done` cycle with `Din=8'h3C` → the second frame begins with exactly one idle-high cycle between the frames.
- **Reset mid-frame.** `reset` asserted during DATA bit 3:
  - next cycle shows `Q=1`, `Busy=0`, and no `Done`;
  - a following `Start` with `Din=8'h81` produces a complete, correct frame.
- **Minimum divider.** CLKS_PER_BIT=1, DATA_W=1, `Din=1'b1` → `Q` sequence 0,1,1 over 3 cycles, then `Done`.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: LSB-first frame transmitter with start bit, optional even parity, and stop bit.
//   En     - clock, rising edge active
//   reset  - synchronous active-high reset
//   Start  - transmit request, honoured only while idle
//   Din    - payload, latched when Start is accepted
//   Q      - serial line, idles high (registered)
//   Busy   - frame in flight (registered)
//   Done   - one-cycle pulse on frame completion (registered)
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              En,
    input  logic              reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Din,
    output logic              Q,
    output logic              Busy,
    output logic              Done
);
    localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;
    state_t            state, state_n;
    logic [TW-1:0]     tick, tick_n;
    logic [IW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              q_n, done_n, bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic              par, par_n;
`endif
    assign bit_end = tick == TW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_n = state;
        tick_n  = tick;
        idx_n   = idx;
        sh_n    = sh;
        done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != S_IDLE)
            tick_n = bit_end ? '0 : tick + TW'(1);
        case (state)
            S_IDLE: if (Start) begin
                state_n = S_START;
                sh_n    = Din;
                tick_n  = '0;
                idx_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
                par_n   = ^Din;
`endif
            end
            S_START: if (bit_end) state_n = S_DATA;
            S_DATA: if (bit_end) begin
                sh_n = sh >> 1;
                if (idx == IW'(DATA_W - 1))
`ifdef SERIAL_TX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                else
                    idx_n = idx + IW'(1);
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: if (bit_end) state_n = S_STOP;
`endif
            S_STOP: if (bit_end) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // Q is registered, so it is derived from the state being entered.
        q_n = (state_n == S_START) ? 1'b0 :
              (state_n == S_DATA)  ? sh_n[0] :
`ifdef SERIAL_TX_PARITY_EN
              (state_n == S_PARITY) ? par_n :
`endif
              1'b1;
    end
    always_ff @(posedge En) begin
        if (reset) begin
            state <= S_IDLE;
            tick  <= '0;
            idx   <= '0;
            sh    <= '0;
            Q     <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tick  <= tick_n;
            idx   <= idx_n;
            sh    <= sh_n;
            Q     <= q_n;
            Busy  <= state_n != S_IDLE;
            Done  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end
endmodule
